// File: rtl/snn_tile_sequencer.sv
// snn_tile_sequencer: multi-tile front-end for SNN_Core; fetches each tile from a 1-cycle pixel SRAM, streams it gap-free to the core, queues one result per tile.
// Latency: oCoreStart the cycle after accept; first pixel beat 3 cycles after the start pulse; result visible at the FIFO head the cycle after the core reports.
// Backpressure: commands are accepted only while idle; a full result FIFO holds the sequencer before the next tile's start pulse.
//
// Ports:
//   iClk, iRst (async, active-low)
//   iCmdValid/oCmdReady, iCmdBase, iCmdTiles       command handshake
//   oMemRd, oMemAddr, iMemData                      pixel SRAM read port (data one cycle after oMemRd)
//   oCoreStart, oCoreData, oCoreValid               start pulse and pixel stream to the core
//   iCoreResult, iCoreValid                         core result
//   oResData, oResTile, oResValid, iResReady        result FIFO head
//   oBusy, oDone, oProtoErr, oTimeout               status
// Optional: define SNN_SEQ_TIMEOUT_EN to abort a command when the core stays silent in WAIT.
module snn_tile_sequencer #(
  parameter int IMAGE_WIDTH    = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int RESULT_WIDTH   = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TILE_CNT_WIDTH = 8,
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = IMAGE_WIDTH + 10
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iCmdValid,
  output logic                      oCmdReady,
  input  logic [ADDR_WIDTH-1:0]     iCmdBase,
  input  logic [TILE_CNT_WIDTH-1:0] iCmdTiles,
  output logic                      oMemRd,
  output logic [ADDR_WIDTH-1:0]     oMemAddr,
  input  logic [DATA_WIDTH-1:0]     iMemData,
  output logic                      oCoreStart,
  output logic [DATA_WIDTH-1:0]     oCoreData,
  output logic                      oCoreValid,
  input  logic [RESULT_WIDTH-1:0]   iCoreResult,
  input  logic                      iCoreValid,
  output logic [RESULT_WIDTH-1:0]   oResData,
  output logic [TILE_CNT_WIDTH-1:0] oResTile,
  output logic                      oResValid,
  input  logic                      iResReady,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oProtoErr,
  output logic                      oTimeout
);

  localparam int PIXELS = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int FA_W   = $clog2(RES_DEPTH);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ENT_W  = RESULT_WIDTH + TILE_CNT_WIDTH;

`ifdef SNN_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  // Abort path compiled out: WAIT waits forever and oTimeout stays 0.
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_NEXT} seqState_t;

  seqState_t                 state, stateNxt;
  logic                      outEn;     // holds oCmdReady low until the first edge after reset release
  logic [ADDR_WIDTH-1:0]     addrCnt;
  logic [TILE_CNT_WIDTH-1:0] tilesQ, tileIdx, tileInc;
  logic [PIX_W-1:0]          pixCnt;
  logic                      lastPix;
  logic                      rdDly;     // oMemRd delayed to line up with SRAM read data
  logic [TO_W-1:0]           waitCnt;
  logic                      accept, push, advance, finish, toFire;

  logic [ENT_W-1:0]          resMem [RES_DEPTH];
  logic [FA_W-1:0]           wrPtr, rdPtr;
  logic [FA_W:0]             fill;
  logic                      fifoFull, pop, wrEn;

  assign oCmdReady  = outEn && (state == S_IDLE);
  assign oCoreStart = (state == S_START);
  assign oMemRd     = (state == S_STREAM);
  assign oBusy      = (state != S_IDLE);
  assign oMemAddr   = addrCnt;
  assign tileInc    = tileIdx + TILE_CNT_WIDTH'(1);
  assign lastPix    = (pixCnt == PIX_W'(PIXELS - 1));

  assign fifoFull  = (fill == (FA_W + 1)'(RES_DEPTH));
  assign oResValid = (fill != '0);
  assign pop       = oResValid && iResReady;
  // The NEXT gate keeps WAIT from seeing a full FIFO within a command; a stale full
  // FIFO left by an earlier command drops the push instead of corrupting the queue.
  assign wrEn      = push && (!fifoFull || pop);
  assign {oResData, oResTile} = oResValid ? resMem[rdPtr] : '0;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= S_IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    accept   = 1'b0;
    push     = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;
    toFire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (iCmdValid && outEn) begin
          accept = 1'b1;
          if (iCmdTiles == '0) finish = 1'b1;
          else                 stateNxt = S_START;
        end
      end
      S_START:  stateNxt = S_STREAM;
      S_STREAM: if (lastPix) stateNxt = S_WAIT;
      S_WAIT: begin
        if (iCoreValid) begin
          push     = 1'b1;
          stateNxt = S_NEXT;
        end else if (TO_EN && (waitCnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
          toFire   = 1'b1;
          finish   = 1'b1;
          stateNxt = S_IDLE;
        end
      end
      S_NEXT: begin
        if (tileInc == tilesQ) begin
          finish   = 1'b1;
          stateNxt = S_IDLE;
        end else if (!fifoFull) begin
          advance  = 1'b1;
          stateNxt = S_START;
        end
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      outEn      <= 1'b0;
      oDone      <= 1'b0;
      addrCnt    <= '0;
      tilesQ     <= '0;
      tileIdx    <= '0;
      pixCnt     <= '0;
      rdDly      <= 1'b0;
      oCoreValid <= 1'b0;
      oCoreData  <= '0;
      oProtoErr  <= 1'b0;
      oTimeout   <= 1'b0;
      waitCnt    <= '0;
    end else begin
      outEn <= 1'b1;
      oDone <= finish;
      if (accept) begin
        addrCnt <= iCmdBase;
        tilesQ  <= iCmdTiles;
        tileIdx <= '0;
      end else if (oMemRd) begin
        addrCnt <= addrCnt + ADDR_WIDTH'(1);  // runs on across tiles, wraps silently
      end
      if (advance) tileIdx <= tileInc;
      if (oMemRd)  pixCnt  <= lastPix ? '0 : pixCnt + PIX_W'(1);
      rdDly      <= oMemRd;
      oCoreValid <= rdDly;
      if (rdDly) oCoreData <= iMemData;
      // A stray result in the same cycle as a new command still counts as seen.
      if (iCoreValid && (state != S_WAIT)) oProtoErr <= 1'b1;
      else if (accept)                     oProtoErr <= 1'b0;
      if (toFire)      oTimeout <= 1'b1;
      else if (accept) oTimeout <= 1'b0;
      waitCnt <= (state == S_WAIT) ? waitCnt + TO_W'(1) : '0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + FA_W'(1);
      if (pop)  rdPtr <= rdPtr + FA_W'(1);
      case ({wrEn, pop})
        2'b10:   fill <= fill + (FA_W + 1)'(1);
        2'b01:   fill <= fill - (FA_W + 1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (wrEn) resMem[wrPtr] <= {iCoreResult, tileIdx};
  end

endmodule

// File: tb/tb_snn_tile_sequencer.sv
// tb_snn_tile_sequencer: directed bench for snn_tile_sequencer with SRAM (data = addr[7:0]) and core responder models.
// Latency: expectations are cycle-exact against the start pulse and result edges.
// Backpressure: iResReady is driven per scenario to exercise the full-FIFO stall.
module tb_snn_tile_sequencer;

  logic        iClk = 1'b0;
  logic        iRst, iCmdValid, iCoreValid, iResReady;
  logic [15:0] iCmdBase;
  logic [7:0]  iCmdTiles, iMemData, iCoreResult;
  logic        oCmdReady, oMemRd, oCoreStart, oCoreValid, oResValid, oBusy, oDone, oProtoErr, oTimeout;
  logic [15:0] oMemAddr;
  logic [7:0]  oCoreData, oResData, oResTile;

  snn_tile_sequencer #(.RES_DEPTH(2)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdBase(iCmdBase), .iCmdTiles(iCmdTiles),
    .oMemRd(oMemRd), .oMemAddr(oMemAddr), .iMemData(iMemData),
    .oCoreStart(oCoreStart), .oCoreData(oCoreData), .oCoreValid(oCoreValid),
    .iCoreResult(iCoreResult), .iCoreValid(iCoreValid),
    .oResData(oResData), .oResTile(oResTile), .oResValid(oResValid), .iResReady(iResReady),
    .oBusy(oBusy), .oDone(oDone), .oProtoErr(oProtoErr), .oTimeout(oTimeout)
  );

  initial forever #5 iClk = ~iClk;

  int nChecks = 0;
  int nErrors = 0;

  // Monitor/responder state (written only by the monitor process).
  int          cyc, nStarts, nReads, nBeats, nDones, addrErr, dataErr, gapErr;
  int          firstStartCyc, startCyc2, firstRdCyc, firstBeatCyc, lastBeatCyc, respCyc0;
  int          cd, respTile, injectAck;
  bit          prevBeat;
  logic [15:0] expAddr, lastAddr, cmdBase;
  // Written only by the main process.
  int          muteTile, resBase, injectReq;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pixel SRAM: one-cycle read latency, content = low address byte.
  initial begin
    iMemData = 8'h00;
    forever begin
      @(posedge iClk);
      if (oMemRd) iMemData <= oMemAddr[7:0];
    end
  end

  // Monitor and core responder, sampling just after the falling edge.
  initial begin
    cyc = 0; nStarts = 0; nReads = 0; nBeats = 0; nDones = 0;
    addrErr = 0; dataErr = 0; gapErr = 0;
    firstStartCyc = 0; startCyc2 = 0; firstRdCyc = 0; firstBeatCyc = 0; lastBeatCyc = 0; respCyc0 = 0;
    cd = 0; respTile = 0; injectAck = 0; prevBeat = 0;
    expAddr = '0; lastAddr = '0; cmdBase = '0;
    iCoreValid = 1'b0; iCoreResult = 8'h00;
    forever begin
      @(negedge iClk);
      #1;
      cyc++;
      iCoreValid = 1'b0;
      if (!iRst) begin
        nBeats = 0; cd = 0; prevBeat = 0;
      end else begin
        if (iCmdValid && oCmdReady) begin
          cmdBase = iCmdBase; expAddr = iCmdBase;
          nStarts = 0; nReads = 0; nBeats = 0; nDones = 0; prevBeat = 0;
        end
        if (oCoreStart) begin
          if (nStarts == 0) firstStartCyc = cyc;
          if (nStarts == 1) startCyc2 = cyc;
          nStarts++;
        end
        if (oMemRd) begin
          if (nReads == 0) firstRdCyc = cyc;
          if (oMemAddr !== expAddr) addrErr++;
          lastAddr = oMemAddr;
          expAddr++;
          nReads++;
        end
        if (oDone) nDones++;
        if (cd > 0) begin
          cd--;
          if (cd == 0 && respTile != muteTile) begin
            iCoreValid  = 1'b1;
            iCoreResult = 8'(resBase + respTile);
            if (respTile == 0) respCyc0 = cyc;
          end
        end
        if (oCoreValid) begin
          if (nBeats % 256 == 0) firstBeatCyc = cyc;
          else if (!prevBeat) gapErr++;
          if (oCoreData !== 8'(cmdBase + nBeats)) dataErr++;
          nBeats++;
          if (nBeats % 256 == 0) begin
            lastBeatCyc = cyc;
            respTile    = nBeats / 256 - 1;
            cd          = 4;
          end
        end
        prevBeat = oCoreValid;
        if (injectReq != injectAck) begin
          injectAck   = injectReq;
          iCoreValid  = 1'b1;
          iCoreResult = 8'hEE;
        end
      end
    end
  end

  task automatic sendCmd(input logic [15:0] base, input logic [7:0] tiles);
    int k = 0;
    @(negedge iClk);
    while (!oCmdReady && k < 50) begin @(negedge iClk); k++; end
    checkVal("cmd_ready", oCmdReady, 1);
    iCmdBase = base; iCmdTiles = tiles; iCmdValid = 1'b1;
    @(negedge iClk);
    iCmdValid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int k = 0;
    while (oDone !== 1'b1 && k < budget) begin @(negedge iClk); k++; end
    checkVal(tag, oDone, 1);
  endtask

  task automatic popCheck(input string tag, input logic [7:0] expData, input logic [7:0] expTile);
    checkVal({tag, "_vld"}, oResValid, 1);
    checkVal({tag, "_dat"}, oResData, expData);
    checkVal({tag, "_tile"}, oResTile, expTile);
    iResReady = 1'b1;
    @(negedge iClk);
    iResReady = 1'b0;
  endtask

  initial begin
    int k;
    bit seen, found;
    iRst = 1'b0; iCmdValid = 1'b0; iCmdBase = '0; iCmdTiles = '0; iResReady = 1'b0;
    muteTile = -1; resBase = 8'h5A; injectReq = 0;

    // Reset state
    repeat (3) @(negedge iClk);
    checkVal("rst_ready", oCmdReady, 0);
    checkVal("rst_busy", oBusy, 0);
    checkVal("rst_resvld", oResValid, 0);
    checkVal("rst_misc", {oMemRd, oCoreStart, oCoreValid, oDone, oProtoErr, oTimeout}, 0);
    iRst = 1'b1;
    #1 checkVal("ready_pre_edge", oCmdReady, 0);
    @(negedge iClk);
    checkVal("ready_after_rst", oCmdReady, 1);

    // Single tile from 0x0100
    sendCmd(16'h0100, 8'd1);
    checkVal("t1_start", oCoreStart, 1);
    checkVal("t1_busy", oBusy, 1);
    checkVal("t1_ready_low", oCmdReady, 0);
    waitDone("t1_done", 400);
    @(negedge iClk);
    checkVal("t1_reads", nReads, 256);
    checkVal("t1_last_addr", lastAddr, 16'h01FF);
    checkVal("t1_beats", nBeats, 256);
    checkVal("t1_rd_lat", firstRdCyc - firstStartCyc, 1);
    checkVal("t1_first_beat", firstBeatCyc - firstStartCyc, 3);
    checkVal("t1_last_beat", lastBeatCyc - firstStartCyc, 258);
    checkVal("t1_dones", nDones, 1);
    checkVal("t1_idle", oBusy, 0);
    popCheck("t1_res", 8'h5A, 8'd0);
    checkVal("t1_empty", oResValid, 0);

    // Three tiles with a two-entry FIFO and no readout
    resBase = 8'h10;
    sendCmd(16'h0200, 8'd3);
    repeat (700) @(negedge iClk);
    checkVal("t2_stall_starts", nStarts, 2);
    checkVal("t2_stall_busy", oBusy, 1);
    checkVal("t2_no_done", nDones, 0);
    checkVal("t2_start2_gap", startCyc2 - respCyc0, 2);
    popCheck("t2_pop0", 8'h10, 8'd0);
    waitDone("t2_done", 400);
    @(negedge iClk);
    checkVal("t2_starts", nStarts, 3);
    checkVal("t2_reads", nReads, 768);
    checkVal("t2_last_addr", lastAddr, 16'h04FF);
    popCheck("t2_pop1", 8'h11, 8'd1);
    popCheck("t2_pop2", 8'h12, 8'd2);
    checkVal("t2_empty", oResValid, 0);

    // Zero tiles
    sendCmd(16'h0300, 8'd0);
    checkVal("t3_done", oDone, 1);
    checkVal("t3_busy", oBusy, 0);
    checkVal("t3_ready", oCmdReady, 1);
    @(negedge iClk);
    checkVal("t3_done_pulse", oDone, 0);
    checkVal("t3_reads", nReads, 0);

    // Stray core result during STREAM
    resBase = 8'h30;
    sendCmd(16'h0400, 8'd1);
    k = 0;
    while (nBeats < 100 && k < 300) begin @(negedge iClk); k++; end
    checkVal("t4_streaming", oMemRd, 1);
    injectReq++;
    repeat (3) @(negedge iClk);
    checkVal("t4_proto", oProtoErr, 1);
    checkVal("t4_no_push", oResValid, 0);
    waitDone("t4_done", 400);
    @(negedge iClk);
    checkVal("t4_proto_sticky", oProtoErr, 1);
    popCheck("t4_res", 8'h30, 8'd0);
    sendCmd(16'h0500, 8'd0);
    checkVal("t4_proto_clr", oProtoErr, 0);

    // Core never answers tile 1 of 4
    resBase = 8'h40; muteTile = 1;
    sendCmd(16'h0600, 8'd4);
    seen = 0; found = 0; k = 0;
    while (!found && k < 1200) begin
      @(negedge iClk); k++;
      if (oMemRd && nStarts >= 2) seen = 1;
      else if (seen && !oMemRd) found = 1;
    end
    checkVal("t5_wait_entry", found, 1);
`ifdef SNN_SEQ_TIMEOUT_EN
    repeat (25) @(negedge iClk);
    checkVal("t5_to_early", oTimeout, 0);
    checkVal("t5_busy_early", oBusy, 1);
    @(negedge iClk);
    checkVal("t5_timeout", oTimeout, 1);
    checkVal("t5_done", oDone, 1);
    checkVal("t5_idle", oBusy, 0);
    @(negedge iClk);
    checkVal("t5_to_sticky", oTimeout, 1);
    checkVal("t5_starts", nStarts, 2);
    checkVal("t5_res_vld", oResValid, 1);
    checkVal("t5_res_dat", oResData, 8'h40);
    checkVal("t5_res_tile", oResTile, 8'd0);
`else
    repeat (100) @(negedge iClk);
    checkVal("t5_hang_busy", oBusy, 1);
    checkVal("t5_no_timeout", oTimeout, 0);
    checkVal("t5_res_dat", oResData, 8'h40);
    iRst = 1'b0;
    #1 checkVal("t5_rst_busy", oBusy, 0);
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
`endif
    muteTile = -1;

    // Reset in the middle of STREAM with a non-empty FIFO
    resBase = 8'h50;
    sendCmd(16'h0800, 8'd1);
    waitDone("t6_pre_done", 400);
    @(negedge iClk);
    checkVal("t6_fifo_nonempty", oResValid, 1);
    sendCmd(16'h0900, 8'd2);
    k = 0;
    while (nReads < 50 && k < 300) begin @(negedge iClk); k++; end
    checkVal("t6_mid_stream", oMemRd, 1);
    iRst = 1'b0;
    #1;
    checkVal("t6_rst_rd", oMemRd, 0);
    checkVal("t6_rst_busy", oBusy, 0);
    checkVal("t6_rst_addr", oMemAddr, 0);
    checkVal("t6_rst_resvld", oResValid, 0);
    checkVal("t6_rst_misc", {oCmdReady, oCoreStart, oCoreValid, oDone}, 0);
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    resBase = 8'h60;
    sendCmd(16'h0A00, 8'd1);
    waitDone("t6_done", 400);
    @(negedge iClk);
    checkVal("t6_reads", nReads, 256);
    checkVal("t6_last_addr", lastAddr, 16'h0AFF);
    checkVal("t6_beats", nBeats, 256);
    popCheck("t6_res", 8'h60, 8'd0);

    // Stream integrity over the whole run
    checkVal("addr_seq", addrErr, 0);
    checkVal("pixel_data", dataErr, 0);
    checkVal("stream_gaps", gapErr, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snn_tile_sequencer.md
# snn_tile_sequencer

Synthesizable tile front-end for `SNN_Core`. It accepts a command naming a base address and a tile count, then for each tile:
- reads `IMAGE_WIDTH*IMAGE_WIDTH` pixels from a 1-cycle-latency pixel SRAM;
- issues the core start pulse and streams the pixels gap-free;
- captures the core's single result per tile into a result FIFO.

It replaces bench-driven single-tile streaming with autonomous multi-tile operation, back-pressured readout and optional hang detection.

## Interface
- `IMAGE_WIDTH`, 16, tile edge; `PIXELS = IMAGE_WIDTH*IMAGE_WIDTH` pixels per tile
- `DATA_WIDTH`, 8, pixel width
- `RESULT_WIDTH`, 8, core result width
- `ADDR_WIDTH`, 16, pixel SRAM address width
- `TILE_CNT_WIDTH`, 8, tile count / tile index width
- `RES_DEPTH`, 4, result FIFO depth (power of 2, ≥2)
- `TIMEOUT_CYCLES`, `IMAGE_WIDTH+10`, WAIT timeout (used only with the macro)

Ports:
- `iClk`  in  1  clock
- `iRst`  in  1  reset, asynchronous, active-low
- `iCmdValid` in 1, `oCmdReady` out 1: command handshake
- `iCmdBase`  in  ADDR_WIDTH  address of pixel 0 of tile 0
- `iCmdTiles`  in  TILE_CNT_WIDTH  number of tiles to run
- `oMemRd` out 1, `oMemAddr` out ADDR_WIDTH: SRAM read request
- `iMemData`  in  DATA_WIDTH  read data, valid the cycle after `oMemRd`
- `oCoreStart`  out  1  one-cycle start pulse to the core
- `oCoreData` out DATA_WIDTH, `oCoreValid` out 1: pixel stream to the core
- `iCoreResult` in RESULT_WIDTH, `iCoreValid` in 1: core result
- `oResData` out RESULT_WIDTH, `oResTile` out TILE_CNT_WIDTH, `oResValid` out 1, `iResReady` in 1: result FIFO head
- `oBusy`  out  1  state ≠ IDLE
- `oDone`  out  1  one-cycle pulse at command completion
- `oProtoErr`  out  1  sticky: `iCoreValid` seen outside WAIT
- `oTimeout`  out  1  sticky: WAIT timeout abort

## Operation
- States and transitions:
  - IDLE: `oCmdReady=1`. On `iCmdValid`, latch base and tiles, clear the stickies, set tile index 0. If tiles=0, pulse `oDone` and stay in IDLE; else go to START.
  - START: `oCoreStart=1` for exactly one cycle, then go to STREAM.
  - STREAM: `oMemRd=1` for `PIXELS` consecutive cycles. The address counter starts at base and increments every read, continuing across tiles (tile t reads `base + t*PIXELS ...`). After the last read, go to WAIT.
  - WAIT: the first `iCoreValid` pushes {result, tile index} into the FIFO, then go to NEXT.
  - NEXT: increment the tile index. If it equals tiles, pulse `oDone` and go to IDLE. Else, if the FIFO is full, stall in NEXT; else go to START.
- Pixel path: the registered delay of `oMemRd` captures `iMemData` into `oCoreData`, with `oCoreValid` high one cycle. Output is gap-free, exactly `PIXELS` beats per tile.
- `iCoreValid` in any state other than WAIT is dropped and sets `oProtoErr`.
- FIFO:
  - Pop when `oResValid & iResReady`.
  - Push and pop in the same cycle are legal at any fill level.
  - Overflow cannot occur, because of the NEXT gating.
  - The FIFO is not cleared by a new command.
- Address counter wraps modulo 2^ADDR_WIDTH, with no error.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0. `oCmdReady` rises the first cycle after reset deassertion. An asserted reset aborts any transfer immediately.

## Timing
- Accept at edge E0. `oCoreStart` is high for E0–E1. `oMemRd` is high for edges E1..E(PIXELS). The first `oCoreValid` follows E3, and the last follows E(PIXELS+2).
- A result in WAIT at edge Er: `oResValid` is high after Er. With FIFO space, the next `oCoreStart` follows Er+1.
- `oDone` is high the cycle after the NEXT→IDLE transition edge. A new command can be accepted on the following edge.

## Configuration
- `SNN_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If `TIMEOUT_CYCLES` cycles pass without `iCoreValid`, set `oTimeout`, skip the remaining tiles, pulse `oDone` and go to IDLE.
  - Results already in the FIFO are kept.
- `SNN_SEQ_TIMEOUT_EN` undefined: WAIT waits indefinitely, and `oTimeout` is tied to 0.

## Test plan
- 1 tile, base 0x0100, SRAM data = addr[7:0], core model returns 0x5A 4 cycles after the last pixel → exactly 256 contiguous `oCoreValid` beats with data 0x00..0xFF; FIFO holds {0x5A, tile 0}; one `oDone`.
- 3 tiles, `iResReady` held low, `RES_DEPTH=2` → the third `oCoreStart` is withheld until one pop; results pop in tile order 0, 1, 2; addresses run contiguously through base+767.
- `iCmdTiles=0` → no `oMemRd`, `oDone` the next cycle, `oBusy` stays 0.
- Core pulses `iCoreValid` during STREAM → `oProtoErr=1`, no FIFO push, tile still completes on the WAIT result; the next command clears `oProtoErr`.
- With the macro: the core never responds on tile 1 of 4 → `oTimeout=1` exactly 26 cycles after entering WAIT, one result in the FIFO, `oDone` pulsed. Without the macro: `oBusy` stays 1.
- Reset asserted mid-STREAM → all outputs 0 asynchronously, FIFO empty; a fresh command afterwards runs normally from the new base.
